// File: rtl/tlc_frame_receiver.sv
// Receive-side deserializer for a TLC5955 daisy-chain stream: decodes RGB triplets,
// checks per-chip select bits and frame length, and reports completion on LAT.
module tlc_frame_receiver #(
  parameter int unsigned NUM_CHIPS         = 2,
  parameter int unsigned TRIPLETS_PER_CHIP = 16,
  parameter int unsigned WORD_BITS         = 16
) (
  input  logic                                            spiClk,
  input  logic                                            reset,
  input  logic                                            SCLK,
  input  logic                                            SDI,
  input  logic                                            LAT,
  output logic                                            busy,
  output logic                                            tripletValid,
  output logic [$clog2(NUM_CHIPS*TRIPLETS_PER_CHIP)-1:0]  tripletAddr,
  output logic [WORD_BITS-1:0]                            red,
  output logic [WORD_BITS-1:0]                            green,
  output logic [WORD_BITS-1:0]                            blue,
  output logic                                            frameDone,
  output logic                                            selErr,
  output logic                                            lenErr
);

  localparam int unsigned TOTAL_TRIPS = NUM_CHIPS * TRIPLETS_PER_CHIP;
  localparam int unsigned ADDR_W      = $clog2(TOTAL_TRIPS);
  localparam int unsigned TPC_W       = $clog2(TRIPLETS_PER_CHIP);
  localparam int unsigned TRIP_BITS   = 3 * WORD_BITS;
  localparam int unsigned BIT_W       = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_DATA,
    S_SELWAIT,
    S_LATWAIT
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             sclk_q, sclk_d;
  logic [2:0]             lat_q, lat_d;
  logic [1:0]             sdi_q, sdi_d;
  logic [TRIP_BITS-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]      trip_cnt_q, trip_cnt_d;
  logic                   sel_bit_q, sel_bit_d;
  logic                   emit_q, emit_d;
  logic                   busy_q, busy_d;
  logic                   trip_valid_q, trip_valid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WORD_BITS-1:0]   red_q, red_d;
  logic [WORD_BITS-1:0]   green_q, green_d;
  logic [WORD_BITS-1:0]   blue_q, blue_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sel_err_q, sel_err_d;
  logic                   len_err_q, len_err_d;

  logic sclk_rise;
  logic lat_rise;
  logic sdi_bit;

  // SCLK/LAT use stage 1 vs stage 2 for edges, so SDI stage 1 lines up with the edge
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lat_rise  = lat_q[1] & ~lat_q[2];
  assign sdi_bit   = sdi_q[1];

  always_comb begin
    state_d      = state_q;
    sclk_d       = {sclk_q[1:0], SCLK};
    lat_d        = {lat_q[1:0], LAT};
    sdi_d        = {sdi_q[0], SDI};
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    trip_cnt_d   = trip_cnt_q;
    sel_bit_d    = sel_bit_q;
    emit_d       = 1'b0;
    busy_d       = busy_q;
    trip_valid_d = 1'b0;
    addr_d       = addr_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    frame_done_d = 1'b0;
    sel_err_d    = 1'b0;
    len_err_d    = 1'b0;

    // A completed triplet is published one cycle after its last bit is shifted in
    if (emit_q) begin
      trip_valid_d = 1'b1;
      blue_d       = shift_q[TRIP_BITS-1 -: WORD_BITS];
      green_d      = shift_q[2*WORD_BITS-1 -: WORD_BITS];
      red_d        = shift_q[WORD_BITS-1:0];
      addr_d       = trip_cnt_q;
      trip_cnt_d   = trip_cnt_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (sclk_rise && !lat_rise) begin
          sel_bit_d = sdi_bit;
          state_d   = S_SEL;
        end
      end
      S_SEL: begin
        if (lat_rise) begin
          len_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (sel_bit_q) begin
          sel_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (lat_rise) begin
          len_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[TRIP_BITS-2:0], sdi_bit};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(TRIP_BITS - 1)) begin
            bit_cnt_d = '0;
            emit_d    = 1'b1;
            if (trip_cnt_q == ADDR_W'(TOTAL_TRIPS - 1)) begin
              state_d = S_LATWAIT;
            end else if (trip_cnt_q[TPC_W-1:0] == TPC_W'(TRIPLETS_PER_CHIP - 1)) begin
              state_d = S_SELWAIT;
            end
          end
        end
      end
      S_SELWAIT: begin
        if (lat_rise) begin
          len_err_d = 1'b1;
          state_d   = S_IDLE;
        end else if (sclk_rise) begin
          sel_bit_d = sdi_bit;
          state_d   = S_SEL;
        end
      end
      S_LATWAIT: begin
        if (lat_rise) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if (sclk_rise) begin
          len_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      busy_d     = 1'b0;
      bit_cnt_d  = '0;
      trip_cnt_d = '0;
    end
  end

  always_ff @(posedge spiClk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sclk_q       <= '0;
      lat_q        <= '0;
      sdi_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      trip_cnt_q   <= '0;
      sel_bit_q    <= 1'b0;
      emit_q       <= 1'b0;
      busy_q       <= 1'b0;
      trip_valid_q <= 1'b0;
      addr_q       <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      sdi_q        <= sdi_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      trip_cnt_q   <= trip_cnt_d;
      sel_bit_q    <= sel_bit_d;
      emit_q       <= emit_d;
      busy_q       <= busy_d;
      trip_valid_q <= trip_valid_d;
      addr_q       <= addr_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
      len_err_q    <= len_err_d;
    end
  end

  assign busy         = busy_q;
  assign tripletValid = trip_valid_q;
  assign tripletAddr  = addr_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign frameDone    = frame_done_q;
  assign selErr       = sel_err_q;
  assign lenErr       = len_err_q;

endmodule

// File: doc/tlc_frame_receiver.md
Name: tlc_frame_receiver

Overview:
- Receive end of the TLC5955 serial LED stream: one SDO lane carrying SCLK, data and LAT.
- Deserializes the daisy-chained frame: per chip, one latch-select bit followed by 16 RGB triplets of 48 bits each, MSB first.
- Emits decoded 16-bit R/G/B words per triplet, a frame-complete pulse on LAT, and protocol error flags.
- Used as an on-FPGA loopback checker and bench monitor for the LED controller output pins.

Parameters:
- NUM_CHIPS, 2, number of daisy-chained TLC5955 devices per frame.
- TRIPLETS_PER_CHIP, 16, RGB triplets per chip.
- WORD_BITS, 16, bits per colour word; a triplet is 3*WORD_BITS.

Ports:
- spiClk  in  1  system/SPI clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- SCLK  in  1  serial clock from the transmitter; may be asynchronous.
- SDI  in  1  serial data lane, sampled on SCLK rising edge.
- LAT  in  1  latch strobe; its rising edge ends the frame.
- busy  out  1  high from the first select bit until frame end or error.
- tripletValid  out  1  one-cycle pulse when a triplet is complete.
- tripletAddr  out  $clog2(NUM_CHIPS*TRIPLETS_PER_CHIP)  arrival index of the triplet, starting at 0.
- red  out  WORD_BITS  last 16 bits received of the triplet.
- green  out  WORD_BITS  middle 16 bits of the triplet.
- blue  out  WORD_BITS  first 16 bits received of the triplet.
- frameDone  out  1  one-cycle pulse on a correctly sized frame latched by LAT.
- selErr  out  1  one-cycle pulse when a select bit equals 1 (control-latch write, unsupported).
- lenErr  out  1  one-cycle pulse when LAT arrives early or an extra SCLK edge follows a complete frame.

Behaviour:
- Input synchronization:
  - SCLK, SDI and LAT each pass through 2 flops, plus a third flop on SCLK and LAT for edge detection. All three paths have equal delay.
  - sclkRise = sync & ~prev; latRise is formed the same way.
  - Transmitter timing requirements: SCLK high ≥1 spiClk and low ≥1 spiClk; SDI stable ≥1 spiClk before and ≥1 after the SCLK rise.
- Reset: state=IDLE. All counters 0. busy, tripletValid, frameDone, selErr, lenErr = 0. red/green/blue/tripletAddr = 0. Sync flops cleared to 0. Reset mid-frame discards the partial frame; no flags fire.
- FSM states:
  - IDLE: on sclkRise, treat the bit as chip 0's select bit → SEL handling. latRise in IDLE is ignored.
  - SEL (entered on a select-bit edge):
    - If SDI=1, pulse selErr next cycle → IDLE, busy=0.
    - Otherwise bitCnt=0, busy=1 → DATA.
  - DATA: each sclkRise shifts SDI into a 48-bit register (left shift, LSB in) and increments bitCnt.
    - When bitCnt reaches 47 on an edge, the next cycle: tripletValid=1, blue=shift[47:32], green=shift[31:16], red=shift[15:0], tripletAddr=tripCnt; tripCnt increments.
    - Latency: SCLK pin rise to tripletValid = 4 spiClk.
    - After the last triplet of a chip that is not the last chip → SELWAIT.
    - After the last triplet of the last chip → LATWAIT.
  - SELWAIT: the next sclkRise is that chip's select bit; handled as in SEL.
  - LATWAIT:
    - latRise → frameDone pulse, busy=0 → IDLE.
    - sclkRise → lenErr pulse → IDLE; the frame is not committed.
- latRise in SEL/DATA/SELWAIT (early latch): lenErr pulse, no frameDone → IDLE. Triplets already emitted stay emitted.
- Simultaneous sclkRise and latRise in the same cycle: LAT takes priority, and the SCLK edge is dropped.
- All outputs are registered. Each flag is high for exactly 1 spiClk. red/green/blue/tripletAddr hold their value until the next tripletValid.
- Counter widths: bitCnt 6 bits; tripCnt $clog2(NUM_CHIPS*TRIPLETS_PER_CHIP) bits; chip boundary when tripCnt[3:0]==15. Counters do not wrap within a legal frame.

Test Plan:
- Full frame, every triplet 0xFFFF/0xFFFF/0xFFFF with select bits 0, then LAT → 32 tripletValid pulses, addr 0..31, all words 0xFFFF, one frameDone, no errors.
- Ramp frame, triplet k = {blue=k, green=0x100+k, red=0xF000+k} → each addr k outputs matching words; frameDone once.
- Chip-1 select bit driven 1 → selErr pulses after addr 15; busy drops; no frameDone on a later LAT.
- LAT after 20 triplets → lenErr pulse, addr stops at 19, no frameDone; next full frame decodes normally from addr 0.
- One extra SCLK edge after triplet 31, before LAT → lenErr; the later LAT is ignored.
- Reset asserted at bit 100 of chip 0, then a full frame → no flags during reset; clean 32 triplets and frameDone.
